// File: rtl/sipo_pkg.sv
// Shared types and constants for the serial-in/parallel-out deserializer.
package sipo_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } state_t;

endpackage

// File: rtl/sipo_deserializer_if.sv
// Serial input / parallel output bundle of the deserializer; master = producer/consumer side.
interface sipo_deserializer_if
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             din;
  logic             din_en;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             overrun;
  logic             parity_err;

  modport master (
    output din, din_en, dout_ready,
    input  dout, dout_valid, overrun, parity_err
  );

  modport slave (
    input  din, din_en, dout_ready,
    output dout, dout_valid, overrun, parity_err
  );

endinterface

// File: rtl/sipo_shift_reg.sv
// WIDTH-bit shift register; MSB_FIRST=1 shifts toward the MSB, 0 shifts toward the LSB.
module sipo_shift_reg
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             bit_in,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      if (MSB_FIRST)
        q <= {q[WIDTH-2:0], bit_in};
      else
        q <= {bit_in, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// Start-bit framed serial-to-parallel deserializer with hold/handshake and sticky overrun.
// Define SIPO_PARITY_EN to append one even-parity bit per frame and report parity_err.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  sipo_deserializer_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
`ifdef SIPO_PARITY_EN
  localparam int unsigned FRAME = WIDTH + 1;
`else
  localparam int unsigned FRAME = WIDTH;
`endif
  localparam logic [CW-1:0] LAST     = CW'(FRAME - 1);
  localparam logic [CW-1:0] DATA_END = CW'(WIDTH);

  state_t           state;
  logic [CW-1:0]    count;
  logic             valid_q;
  logic             ovr_q;
  logic [WIDTH-1:0] word;
  logic             load;
  logic             handshake;
  logic             start_seen;

  assign handshake  = valid_q & bus.dout_ready;
  assign start_seen = bus.din_en & bus.din;
  // The parity bit (count == WIDTH) is sampled but never shifted into the data word.
  assign load       = (state == SHIFT) && bus.din_en && (count < DATA_END);

  sipo_shift_reg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_shift (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .bit_in(bus.din),
    .q     (word)
  );

`ifdef SIPO_PARITY_EN
  logic par_acc;
  logic perr_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef SIPO_PARITY_EN
      par_acc <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start_seen) begin
            state <= SHIFT;
            count <= '0;
`ifdef SIPO_PARITY_EN
            par_acc <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          if (bus.din_en) begin
            if (count == LAST) begin
              state   <= HOLD;
              count   <= '0;
              valid_q <= 1'b1;
`ifdef SIPO_PARITY_EN
              perr_q  <= par_acc ^ bus.din;
`endif
            end else begin
              count <= count + CW'(1);
            end
`ifdef SIPO_PARITY_EN
            par_acc <= par_acc ^ bus.din;
`endif
          end
        end
        HOLD: begin
          if (handshake) begin
            valid_q <= 1'b0;
`ifdef SIPO_PARITY_EN
            perr_q  <= 1'b0;
`endif
            // A start bit on the handshake edge begins the next frame immediately.
            if (start_seen) begin
              state <= SHIFT;
              count <= '0;
`ifdef SIPO_PARITY_EN
              par_acc <= 1'b0;
`endif
            end else begin
              state <= IDLE;
            end
          end else if (bus.din_en) begin
            ovr_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dout       = word;
  assign bus.dout_valid = valid_q;
  assign bus.overrun    = ovr_q;
`ifdef SIPO_PARITY_EN
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: an MSB-first and an LSB-first instance share one stimulus.
module tb_sipo_deserializer;
  import sipo_pkg::*;

  localparam int unsigned W = 8;
`ifdef SIPO_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic din = 1'b0;
  logic din_en = 1'b0;
  logic rdy = 1'b0;

  sipo_deserializer_if #(.WIDTH(W)) bm ();
  sipo_deserializer_if #(.WIDTH(W)) bl ();

  assign bm.din = din;
  assign bm.din_en = din_en;
  assign bm.dout_ready = rdy;
  assign bl.din = din;
  assign bl.din_en = din_en;
  assign bl.dout_ready = rdy;

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .bus(bm.slave));
  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .bus(bl.slave));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       d;
    logic       e;
    logic       r;
    logic       v;
    logic [7:0] dout;
    logic       ovr;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic d, input logic e, input logic r);
    din = d;
    din_en = e;
    rdy = r;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] y;
    for (int i = 0; i < 8; i++) y[i] = x[7-i];
    return y;
  endfunction

  function automatic vec_t mk(input logic d, input logic e, input logic r,
                              input logic v, input logic [7:0] dout, input logic ovr);
    vec_t t;
    t.d = d; t.e = e; t.r = r; t.v = v; t.dout = dout; t.ovr = ovr;
    return t;
  endfunction

  // Start bit, data MSB of w first, then parity bit when enabled; ready held low.
  task automatic send_frame(input logic [7:0] w, input logic pbit);
    cyc(1'b1, 1'b1, 1'b0);
    for (int i = 7; i >= 0; i--) cyc(w[i], 1'b1, 1'b0);
    if (PAR) cyc(pbit, 1'b1, 1'b0);
  endtask

  logic [7:0] a5 = 8'hA5;
  logic [7:0] w96 = 8'h96;
  logic       bits[$];

  initial begin
    // Reset state
    #12;
    check("rst_dout_m", bm.dout, 8'h00);
    check("rst_dout_l", bl.dout, 8'h00);
    check("rst_valid", bm.dout_valid, 1'b0);
    check("rst_ovr", bm.overrun, 1'b0);
    check("rst_perr", bm.parity_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 1'b1, 1'b0);

    // Basic frame A5 through hold and handshake
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0));
    for (int i = 7; i >= 0; i--)
      tbl.push_back(mk(a5[i], 1'b1, 1'b0, (i == 0) && !PAR, 8'hA5, 1'b0));
    if (PAR) tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0));
    for (int k = 0; k < tbl.size(); k++) begin
      cyc(tbl[k].d, tbl[k].e, tbl[k].r);
      check($sformatf("tbl%0d_valid_m", k), bm.dout_valid, tbl[k].v);
      check($sformatf("tbl%0d_valid_l", k), bl.dout_valid, tbl[k].v);
      check($sformatf("tbl%0d_ovr", k), bm.overrun, tbl[k].ovr);
      check($sformatf("tbl%0d_perr", k), bm.parity_err, 1'b0);
      if (tbl[k].v) begin
        check($sformatf("tbl%0d_dout_m", k), bm.dout, tbl[k].dout);
        check($sformatf("tbl%0d_dout_l", k), bl.dout, tbl[k].dout);
      end
    end

    // din_en toggling every cycle; disabled cycles carry inverted junk
    bits.push_back(1'b1);
    for (int i = 7; i >= 0; i--) bits.push_back(a5[i]);
    if (PAR) bits.push_back(1'b0);
    for (int k = 0; k < bits.size(); k++) begin
      cyc(bits[k], 1'b1, 1'b0);
      check($sformatf("tog%0d_valid_on", k), bm.dout_valid, k == bits.size() - 1);
      cyc(!bits[k], 1'b0, 1'b0);
      check($sformatf("tog%0d_valid_off", k), bm.dout_valid, k == bits.size() - 1);
    end
    check("tog_dout_m", bm.dout, 8'hA5);
    check("tog_dout_l", bl.dout, 8'hA5);
    check("tog_ovr", bm.overrun, 1'b0);

    // Stall in hold with three sampled bits
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    check("stall_dout", bm.dout, 8'hA5);
    check("stall_valid", bm.dout_valid, 1'b1);
    check("stall_ovr", bm.overrun, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    check("hs_valid", bm.dout_valid, 1'b0);
    check("hs_ovr_sticky", bm.overrun, 1'b1);
    send_frame(8'h3C, 1'b0);
    check("idle_after_hs_valid", bm.dout_valid, 1'b1);
    check("idle_after_hs_dout", bm.dout, 8'h3C);
    check("ovr_still", bm.overrun, 1'b1);

    // Back-to-back: start bit on the handshake edge
    cyc(1'b1, 1'b1, 1'b1);
    check("b2b_valid_drop", bm.dout_valid, 1'b0);
    for (int i = 7; i >= 0; i--) cyc(w96[i], 1'b1, 1'b0);
    if (PAR) cyc(1'b0, 1'b1, 1'b0);
    check("b2b_valid", bm.dout_valid, 1'b1);
    check("b2b_dout_m", bm.dout, 8'h96);
    check("b2b_dout_l", bl.dout, rev8(8'h96));
    cyc(1'b0, 1'b0, 1'b1);

    // Reset after four data bits
    cyc(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0);
    din_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #2;
    check("arst_dout", bm.dout, 8'h00);
    check("arst_ovr", bm.overrun, 1'b0);
    check("arst_valid", bm.dout_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(8'h3C, 1'b0);
    check("postrst_valid", bm.dout_valid, 1'b1);
    check("postrst_dout_m", bm.dout, 8'h3C);
    check("postrst_dout_l", bl.dout, 8'h3C);
    check("postrst_ovr", bm.overrun, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);

`ifdef SIPO_PARITY_EN
    send_frame(8'hA5, 1'b1);
    check("par_bad_valid", bm.dout_valid, 1'b1);
    check("par_bad_err", bm.parity_err, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    check("par_clear_on_hs", bm.parity_err, 1'b0);
    send_frame(8'hA5, 1'b0);
    check("par_good_valid", bm.dout_valid, 1'b1);
    check("par_good_err", bm.parity_err, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
`else
    send_frame(8'hA5, 1'b1);
    check("nopar_valid", bm.dout_valid, 1'b1);
    check("nopar_err", bm.parity_err, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
